sub_serial: RTL and testbench
=============================

Name: sub_serial

Overview:
Bit-serial 8-bit subtractor; the inverse-operation companion of the team's serial adder. It computes out = a - b LSB-first, one bit per clock, through a single full-subtractor cell. It also produces a final borrow flag. It sits beside the adder in the serial arithmetic datapath and uses the same en-driven IDLE/run/DONE handshake.

Parameters:
WIDTH, 8, operand and result width in bits (supported 2..32)
CNT_W, $clog2(WIDTH), width of the bit counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; one clock; reset is asynchronous and active-low (rst=0 resets)
en  input  1  start/acknowledge strobe, active-high, sampled in IDLE and DONE only
a  input  WIDTH  minuend, sampled on the IDLE edge where en=1
b  input  WIDTH  subtrahend, sampled on the same edge as a
out  output  WIDTH  difference a-b mod 2^WIDTH, valid while done=1
borrow  output  1  1 when a<b (unsigned), valid while done=1
done  output  1  high exactly while state==DONE

Behaviour:
- Reset (rst=0, asynchronous, any state): state=IDLE; out, a_reg, b_reg, count, brw, borrow all 0; done=0.
- State register: IDLE=0, SUB=1, DONE=2. Encoding 3 is illegal; it returns to IDLE on the next edge with all datapath registers cleared.
- IDLE, en=1 at edge: a_reg<=a, b_reg<=b, out<=0, count<=0, brw<=0, borrow<=0, state<=SUB.
- IDLE, en=0: hold all registers.
- SUB, every edge:
  - d = a_reg[0]^b_reg[0]^brw.
  - out <= {d, out[WIDTH-1:1]}.
  - brw <= (~a_reg[0]&b_reg[0]) | (~a_reg[0]&brw) | (b_reg[0]&brw).
  - a_reg <= a_reg>>1, b_reg <= b_reg>>1 (zero fill), count <= count+1.
- SUB exit: when count==WIDTH-1 at the edge, state<=DONE and borrow<=next brw (same edge as the last out shift). Otherwise stay in SUB.
- en is ignored in SUB. Toggling en during SUB must not alter the result or the timing.
- DONE:
  - out and borrow hold; done=1.
  - en=1 at edge: state<=IDLE; out and borrow keep their values until the next load.
  - en=0: stay in DONE.
- Latency: with en=1 on IDLE edge k, results are valid and done=1 after edge k+WIDTH.
  - For WIDTH=8: 8 SUB cycles, done asserted after the 9th edge counted from and including k.
- Back-to-back operation with en held high:
  - IDLE -> SUB (WIDTH edges) -> DONE (1 edge) -> IDLE (1 edge) -> reload.
  - Period is WIDTH+2 edges; a new a/b is sampled every WIDTH+2 cycles.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - Two's-complement signed interpretation of out is also correct.
  - borrow is NOT signed overflow.
- done is decoded from the state register only (no input path), so it is glitch-free relative to inputs.
- Reset mid-SUB: partial out is discarded and the registers are zeroed immediately; no spurious done.

Decomposition:
- Shared package sub_serial_pkg:
  - state enum/constants IDLE, SUB, DONE (2-bit);
  - default WIDTH constant;
  - a function for the next-borrow expression, reused by the adder/subtractor family.
- One natural sub-module: full_sub_cell, combinational, inputs x, y, bin, outputs d, bout.
  - Instantiate it once.
  - Keep it purely combinational so the cell can be verified exhaustively (8 vectors) on its own.

Test Plan:
- Reset, then a=0x5A, b=0x23, en pulse 1 cycle -> after 9 edges done=1, out=0x37, borrow=0; out holds while en=0.
- a=0x10, b=0x20 -> out=0xF0, borrow=1; a=0x00, b=0x01 -> out=0xFF, borrow=1 (full borrow ripple).
- a=0xFF, b=0xFF -> out=0x00, borrow=0. a=0x80, b=0x7F -> out=0x01, borrow=0.
- en held high continuously, operands changed each load -> results every 10 cycles, each correct. en toggled randomly during SUB -> no effect on the result or on when done asserts.
- rst=0 asserted asynchronously (between clock edges) at the 4th SUB cycle:
  - out=0, borrow=0, done=0, state=IDLE immediately;
  - after release, a=0x33, b=0x11 -> out=0x22.
- Random 1000 pairs vs. the reference model (a-b)&0xFF, with borrow=(a<b); also run with WIDTH=16, e.g. a=0x0001, b=0x0002 -> out=0xFFFF, borrow=1.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// sub_serial_pkg: shared types and helpers for the serial add/subtract family
//   state_t     : 2-bit FSM encoding IDLE=0, SUB=1, DONE=2 (3 is illegal)
//   DEF_WIDTH   : default operand width
//   next_borrow : borrow-out of a single full-subtractor bit x - y - bin
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic logic next_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~x & bin) | (y & bin);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: one-bit combinational full subtractor computing x - y - bin
//   x, y : minuend / subtrahend bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_sub_cell
    import sub_serial_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = next_borrow(x, y, bin);

endmodule

// File: rtl/sub_serial.sv
// sub_serial: bit-serial LSB-first subtractor, out = a - b mod 2^WIDTH
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   en     : start strobe in IDLE, acknowledge strobe in DONE, ignored in SUB
//   a, b   : minuend / subtrahend, sampled on the starting IDLE edge
//   out    : difference, valid while done=1
//   borrow : 1 when a < b unsigned, valid while done=1
//   done   : high exactly while in DONE
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             brw_q, borrow_q;
    logic             diff_d, brw_d;

    full_sub_cell u_cell (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .bin (brw_q),
        .d   (diff_d),
        .bout(brw_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (en) begin
                    a_q      <= a;
                    b_q      <= b;
                    out_q    <= '0;
                    cnt_q    <= '0;
                    brw_q    <= 1'b0;
                    borrow_q <= 1'b0;
                    state_q  <= SUB;
                end
                SUB: begin
                    // difference bits enter at the MSB so bit 0 lands at out[0] after WIDTH shifts
                    out_q <= {diff_d, out_q[WIDTH-1:1]};
                    brw_q <= brw_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        borrow_q <= brw_d;
                        state_q  <= DONE;
                    end
                end
                DONE: if (en) state_q <= IDLE;
                default: begin
                    state_q  <= IDLE;
                    a_q      <= '0;
                    b_q      <= '0;
                    out_q    <= '0;
                    cnt_q    <= '0;
                    brw_q    <= 1'b0;
                    borrow_q <= 1'b0;
                end
            endcase
        end
    end

    assign out    = out_q;
    assign borrow = borrow_q;
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed and random checks of sub_serial at WIDTH=8 and WIDTH=16
module tb_sub_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en8 = 1'b0, en16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, out8;
    logic [15:0] a16 = '0, b16 = '0, out16;
    logic        bor8, bor16, done8, done16;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sub_serial dut8 (
        .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8),
        .out(out8), .borrow(bor8), .done(done8)
    );

    sub_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .en(en16), .a(a16), .b(b16),
        .out(out16), .borrow(bor16), .done(done16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input bit wide, input logic v);
        if (wide) en16 = v;
        else en8 = v;
    endtask

    // One complete transaction: load, wait for done with a bounded budget, verify
    // latency and result, verify hold with en=0, then acknowledge back to IDLE.
    task automatic op(input bit wide, input logic [15:0] av, input logic [15:0] bv, input bit tog);
        int          n;
        int          w;
        logic [15:0] mask, exp_out;
        logic        exp_bor;
        w       = wide ? 16 : 8;
        mask    = wide ? 16'hFFFF : 16'h00FF;
        exp_out = (av - bv) & mask;
        exp_bor = (av & mask) < (bv & mask);
        if (wide) begin a16 = av; b16 = bv; end
        else begin a8 = av[7:0]; b8 = bv[7:0]; end
        set_en(wide, 1'b1);
        step();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            set_en(wide, tog ? 1'($urandom) : 1'b0);
            if (wide) begin a16 = 16'($urandom); b16 = 16'($urandom); end
            else begin a8 = 8'($urandom); b8 = 8'($urandom); end
            step();
            n++;
            if (wide ? done16 : done8) break;
        end
        set_en(wide, 1'b0);
        check("latency", 32'(n), 32'(w));
        check("out", wide ? 32'(out16) : 32'(out8), 32'(exp_out));
        check("borrow", wide ? 32'(bor16) : 32'(bor8), 32'(exp_bor));
        step();
        check("done_hold", wide ? 32'(done16) : 32'(done8), 32'd1);
        set_en(wide, 1'b1);
        step();
        set_en(wide, 1'b0);
        check("done_ack", wide ? 32'(done16) : 32'(done8), 32'd0);
        check("out_keep", wide ? 32'(out16) : 32'(out8), 32'(exp_out));
    endtask

    initial begin
        logic [7:0] ta, tb;
        #12;
        check("rst_out8", 32'(out8), 32'd0);
        check("rst_bor8", 32'(bor8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_out16", 32'(out16), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        rst = 1'b1;
        step();
        op(0, 16'h5A, 16'h23, 0);
        op(0, 16'h10, 16'h20, 0);
        op(0, 16'h00, 16'h01, 0);
        op(0, 16'hFF, 16'hFF, 0);
        op(0, 16'h80, 16'h7F, 0);
        op(0, 16'h37, 16'hC4, 1);
        op(1, 16'h0001, 16'h0002, 0);
        op(1, 16'h8000, 16'h0001, 1);
        // en held high: a new pair is sampled every WIDTH+2 edges
        en8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ta = 8'($urandom);
            tb = 8'($urandom);
            a8 = ta;
            b8 = tb;
            step();
            repeat (7) step();
            check("b2b_not_done", 32'(done8), 32'd0);
            step();
            check("b2b_done", 32'(done8), 32'd1);
            check("b2b_out", 32'(out8), 32'(8'(ta - tb)));
            check("b2b_borrow", 32'(bor8), 32'(ta < tb));
            step();
            check("b2b_idle", 32'(done8), 32'd0);
        end
        en8 = 1'b0;
        step();
        // asynchronous reset in the middle of the 4th SUB cycle
        a8 = 8'h5A;
        b8 = 8'h23;
        en8 = 1'b1;
        step();
        en8 = 1'b0;
        repeat (3) step();
        #3 rst = 1'b0;
        #1;
        check("arst_out", 32'(out8), 32'd0);
        check("arst_bor", 32'(bor8), 32'd0);
        check("arst_done", 32'(done8), 32'd0);
        step();
        check("arst_hold_done", 32'(done8), 32'd0);
        rst = 1'b1;
        step();
        check("arst_idle_done", 32'(done8), 32'd0);
        op(0, 16'h33, 16'h11, 0);
        for (int k = 0; k < 1000; k++)
            op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom));
        for (int k = 0; k < 40; k++)
            op(1, 16'($urandom), 16'($urandom), 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
